// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter.
// Pure types/constants: no latency, no backpressure.
package regfile_wport_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WB,
    REQ_JAL,
    REQ_LU
  } req_e;

  typedef enum logic {
    NORM,
    FORCE
  } state_e;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Request-side bundle: WB, JAL link and long-latency unit writes, plus grant/stall back.
// No latency of its own; LU backpressure via lu_ready, pipeline backpressure via stall_o.
interface regfile_wport_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              jal_valid;
  logic [DATA_W-1:0] jal_link;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              stall_o;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output jal_valid, jal_link,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready, stall_o
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  jal_valid, jal_link,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready, stall_o
  );

endinterface

// File: rtl/regfile_wport_arbiter_starve_timer.sv
// Counts consecutive cycles the LU waits; raises force_lu for one cycle at the limit.
// force_lu is registered state; the timer itself never backpressures.
module wport_starve_timer #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic lu_valid,
  input  logic lu_ready,
  output logic force_lu
);
  import regfile_wport_arbiter_pkg::*;

  logic [3:0] wait_cnt_q, wait_cnt_d;
  state_e     state_q, state_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
      state_q    <= NORM;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    state_d    = NORM;
    if (lu_valid && !lu_ready) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    // FORCE lasts one cycle; the LU transfer inside it clears the count.
    if (state_q == NORM && wait_cnt_d == 4'(STARVE_LIMIT)) begin
      state_d = FORCE;
    end
  end

  assign force_lu = (state_q == FORCE);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port: WB > JAL > LU, LU forced after starving.
// Grant/stall combinational, write port registered (1 cycle); losers stall or see lu_ready=0.
module regfile_wport_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  regfile_wport_arbiter_if.slave req,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      wa_o,
  output logic [DATA_W-1:0]      wd_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  import regfile_wport_arbiter_pkg::*;

  req_e                   grant;
  logic                   force_lu;
  logic                   lu_ready;
  logic                   stall;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_data;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      wa_q, wa_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  wport_starve_timer #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .lu_valid (req.lu_valid),
    .lu_ready (lu_ready),
    .force_lu (force_lu)
  );

  // Nothing is granted while reset is held, so handshakes stay quiet.
  always_comb begin
    grant = REQ_NONE;
    if (RST) begin
      if (force_lu)           grant = REQ_LU;
      else if (req.wb_valid)  grant = REQ_WB;
      else if (req.jal_valid) grant = REQ_JAL;
      else if (req.lu_valid)  grant = REQ_LU;
    end
  end

  assign lu_ready     = (grant == REQ_LU);
  assign stall        = RST && ((req.wb_valid  && grant != REQ_WB) ||
                                (req.jal_valid && grant != REQ_JAL));
  assign req.lu_ready = lu_ready;
  assign req.stall_o  = stall;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (grant)
      REQ_WB:  begin sel_addr = req.wb_addr;         sel_data = req.wb_data;  end
      REQ_JAL: begin sel_addr = ADDR_W'(LINK_REG);   sel_data = req.jal_link; end
      REQ_LU:  begin sel_addr = req.lu_addr;         sel_data = req.lu_data;  end
      default: begin sel_addr = '0;                  sel_data = '0;           end
    endcase
  end

  // r0 grants complete the handshake but leave the write port idle.
  always_comb begin
    we_d        = (grant != REQ_NONE) && (sel_addr != '0);
    wa_d        = we_d ? sel_addr : wa_q;
    wd_d        = we_d ? sel_data : wd_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign we_o        = we_q;
  assign wa_o        = wa_q;
  assign wd_o        = wd_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: vector table plus starvation, reset-in-FORCE and saturation sequences.
module tb_regfile_wport_arbiter;

  logic        CLK;
  logic        RST;
  logic        we_o;
  logic [4:0]  wa_o;
  logic [31:0] wd_o;
  logic [3:0]  stall_cnt_o;

  regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wport_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .STALL_CNT_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .req(bus),
    .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o), .stall_cnt_o(stall_cnt_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wv;  logic [4:0] wa;  logic [31:0] wd;
    logic        jv;  logic [31:0] jl;
    logic        lv;  logic [4:0] la;  logic [31:0] ld;
    logic        rdy; logic       st;
    logic        we;  logic [4:0] ewa; logic [31:0] ewd; logic [3:0] cnt;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [3:0] cnt;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  vec_t        tbl[11];
  logic        pend;
  logic [4:0]  p_addr;
  logic [31:0] p_data;

  function automatic vec_t mk(logic wv, logic [4:0] wa, logic [31:0] wd, logic jv,
                              logic [31:0] jl, logic lv, logic [4:0] la, logic [31:0] ld,
                              logic rdy, logic st, logic we, logic [4:0] ewa,
                              logic [31:0] ewd, logic [3:0] cnt);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.jv = jv; v.jl = jl;
    v.lv = lv; v.la = la; v.ld = ld; v.rdy = rdy; v.st = st;
    v.we = we; v.ewa = ewa; v.ewd = ewd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    bus.wb_valid = v.wv; bus.wb_addr = v.wa; bus.wb_data = v.wd;
    bus.jal_valid = v.jv; bus.jal_link = v.jl;
    bus.lu_valid = v.lv; bus.lu_addr = v.la; bus.lu_data = v.ld;
    #1;
    chk("lu_ready", 32'(bus.lu_ready), 32'(v.rdy));
    chk("stall_o", 32'(bus.stall_o), 32'(v.st));
    e.we = v.we; e.wa = v.ewa; e.wd = v.ewd; e.cnt = v.cnt;
    sb.push_back(e);
    @(negedge CLK);
    // A waiting LU must keep its request stable until it is granted.
    if (pend)
      chk("lu_hold", 32'(bus.lu_valid && bus.lu_addr == p_addr && bus.lu_data == p_data), 32'd1);
    pend   = bus.lu_valid && !bus.lu_ready;
    p_addr = bus.lu_addr;
    p_data = bus.lu_data;
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("we_o", 32'(we_o), 32'(e.we));
    chk("wa_o", 32'(wa_o), 32'(e.wa));
    chk("wd_o", wd_o, e.wd);
    chk("stall_cnt_o", 32'(stall_cnt_o), 32'(e.cnt));
  endtask

  task automatic clear_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.jal_valid = 1'b0; bus.jal_link = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    bus.wb_valid = 1'b1; bus.jal_valid = 1'b1; bus.lu_valid = 1'b1; bus.lu_addr = 5'd1;
    #1;
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_wa", 32'(wa_o), 32'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    clear_inputs();
    pend = 1'b0;
    RST  = 1'b1;
  endtask

  initial begin
    pend = 1'b0; p_addr = '0; p_data = '0;
    clear_inputs();
    do_reset();

    //            wv   wa     wd          jv   jl            lv   la    ld          rdy  st   we   ewa    ewd           cnt
    tbl[0]  = mk(1'b1, 5'd8,  32'h1234,   1'b0, 32'h0,       1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd8,  32'h1234,     4'd0);
    tbl[1]  = mk(1'b1, 5'd31, 32'hA,      1'b1, 32'h400104,  1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd31, 32'hA,        4'd1);
    tbl[2]  = mk(1'b0, 5'd0,  32'h0,      1'b1, 32'h400104,  1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd31, 32'h400104,   4'd1);
    tbl[3]  = mk(1'b0, 5'd0,  32'h0,      1'b0, 32'h0,       1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 5'd31, 32'h400104,   4'd1);
    tbl[4]  = mk(1'b0, 5'd0,  32'h0,      1'b0, 32'h0,       1'b1, 5'd0, 32'h55,   1'b1, 1'b0, 1'b0, 5'd31, 32'h400104,   4'd1);
    tbl[5]  = mk(1'b0, 5'd0,  32'h0,      1'b1, 32'h1000,    1'b1, 5'd3, 32'h33,   1'b0, 1'b0, 1'b1, 5'd31, 32'h1000,     4'd1);
    tbl[6]  = mk(1'b0, 5'd0,  32'h0,      1'b0, 32'h0,       1'b1, 5'd3, 32'h33,   1'b1, 1'b0, 1'b1, 5'd3,  32'h33,       4'd1);
    tbl[7]  = mk(1'b1, 5'd0,  32'h99,     1'b1, 32'h2000,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd3,  32'h33,       4'd2);
    tbl[8]  = mk(1'b0, 5'd0,  32'h0,      1'b1, 32'h2000,    1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd31, 32'h2000,     4'd2);
    tbl[9]  = mk(1'b1, 5'd7,  32'h77,     1'b0, 32'h0,       1'b1, 5'd9, 32'h99,   1'b0, 1'b0, 1'b1, 5'd7,  32'h77,       4'd2);
    tbl[10] = mk(1'b0, 5'd0,  32'h0,      1'b0, 32'h0,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b1, 5'd9,  32'h99,       4'd2);
    for (int i = 0; i < 11; i++) step(tbl[i]);

    // Starvation: WB every cycle keeps LU out until the timer forces it.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 5'(10 + i), 32'(i), 1'b0, 32'h0, 1'b1, 5'd5, 32'hBEEF,
              1'b0, 1'b0, 1'b1, 5'(10 + i), 32'(i), 4'd0));
    step(mk(1'b1, 5'd14, 32'd4, 1'b0, 32'h0, 1'b1, 5'd5, 32'hBEEF,
            1'b1, 1'b1, 1'b1, 5'd5, 32'hBEEF, 4'd1));
    step(mk(1'b1, 5'd14, 32'd4, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 1'b1, 5'd14, 32'd4, 4'd1));

    // Reset asserted during the FORCE cycle, LU request held across it.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 5'(20 + i), 32'(20 + i), 1'b0, 32'h0, 1'b1, 5'd6, 32'h600D,
              1'b0, 1'b0, 1'b1, 5'(20 + i), 32'(20 + i), 4'd0));
    bus.wb_addr = 5'd24; bus.wb_data = 32'd24;
    #1;
    chk("force_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("force_stall", 32'(bus.stall_o), 32'd1);
    RST = 1'b0;
    #1;
    chk("midrst_lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("midrst_stall", 32'(bus.stall_o), 32'd0);
    chk("midrst_we", 32'(we_o), 32'd0);
    chk("midrst_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.wb_valid = 1'b0;
    #1;
    chk("rel_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rel_stall", 32'(bus.stall_o), 32'd0);
    @(posedge CLK);
    #1;
    chk("rel_we", 32'(we_o), 32'd1);
    chk("rel_wa", 32'(wa_o), 32'd6);
    chk("rel_wd", wd_o, 32'h600D);
    bus.lu_valid = 1'b0;
    pend = 1'b0;

    // Stall counter saturation with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(mk(1'b1, 5'd1, 32'd1, 1'b1, 32'h3000, 1'b0, 5'd0, 32'h0,
              1'b0, 1'b1, 1'b1, 5'd1, 32'd1, (i + 1 > 15) ? 4'd15 : 4'(i + 1)));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) between three requesters:
  - pipeline writeback (WB)
  - JAL link write to r31 (JAL)
  - long-latency unit (LU: mult/div/uncached load) via valid/ready handshake
- Uses fixed priority plus an anti-starvation timer for LU.
- Generates the pipeline stall when a pipeline requester loses arbitration.
- Sits between the WB/decode stages and the register file; its registered outputs drive WE3/A3/WD3 directly.

Parameters:
- DATA_W, 32, write-data width.
- ADDR_W, 5, register address width.
- STARVE_LIMIT, 4, consecutive cycles LU may wait with lu_valid=1 before it is forced through (1..15).
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- CLK  in  1  clock; arbitration state updates on posedge.
- RST  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  WB write request.
- wb_addr  in  ADDR_W  WB destination register.
- wb_data  in  DATA_W  WB write data.
- jal_valid  in  1  JAL link write request; destination is fixed to r31.
- jal_link  in  DATA_W  PC+4 link value.
- lu_valid  in  1  LU write request.
- lu_addr  in  ADDR_W  LU destination register.
- lu_data  in  DATA_W  LU write data.
- lu_ready  out  1  LU grant (combinational); transfer occurs when lu_valid & lu_ready.
- stall_o  out  1  combinational; pipeline must hold WB and JAL requests unchanged.
- we_o  out  1  registered write enable to the register file.
- wa_o  out  ADDR_W  registered write address.
- wd_o  out  DATA_W  registered write data.
- stall_cnt_o  out  STALL_CNT_W  saturating count of cycles with stall_o=1.

Behaviour:
- Reset (RST=0, async):
  - we_o=0, wa_o=0, wd_o=0, stall_cnt_o=0.
  - wait_cnt=0, state=NORM.
  - lu_ready=0 and stall_o=0 while RST=0.
- States: NORM and FORCE.
  - NORM priority: WB > JAL > LU. WB is the oldest instruction, so WB wins a WB/JAL tie even when wb_addr=31.
  - FORCE: LU is granted unconditionally (lu_valid is guaranteed 1 on entry); WB and JAL lose.
- Grant is combinational each cycle.
  - stall_o=1 iff a valid WB or JAL request is not granted that cycle.
  - lu_ready=1 iff LU is granted.
- Output latency: the granted request appears on we_o/wa_o/wd_o at the next posedge, so the register file commits it at the following negedge.
  - If nothing is granted: we_o=0; wa_o/wd_o hold their previous values.
- r0 writes: a granted request with address 0 is consumed (handshake completes, no stall) but drives we_o=0.
- JAL grant drives wa_o=31, wd_o=jal_link.
- wait_cnt (4 bits):
  - Increments each cycle that lu_valid=1 and lu_ready=0.
  - Clears on any LU transfer or when lu_valid=0.
- Transitions:
  - NORM->FORCE at the posedge where wait_cnt reaches STARVE_LIMIT (the next-state value equals STARVE_LIMIT).
  - FORCE->NORM after exactly one cycle. The LU transfer happens in the FORCE cycle.
- LU protocol: once lu_valid=1, the LU holds addr/data stable until the transfer. Arbiter behaviour is undefined if lu_valid drops before transfer; the bench must flag it.
- Ordering: LU and pipeline requests are independent streams. The hazard unit, not this block, guarantees no same-register WAW between LU and WB.
- stall_cnt_o increments on each posedge where stall_o=1 and saturates at all-ones.
- Reset mid-FORCE: immediately returns to NORM with wait_cnt=0. A pending LU request re-arbitrates from zero wait after reset release.

Decomposition:
- Shared package:
  - Requester encoding (REQ_NONE, REQ_WB, REQ_JAL, REQ_LU).
  - State encoding (NORM, FORCE).
  - LINK_REG=5'd31.
- One sub-module: wport_starve_timer (wait_cnt, compare against STARVE_LIMIT, FORCE flag).
- Grant mux and output registers stay in the top module.

Test Plan:
1. WB only: wb_valid=1, addr=8, data=0x1234 -> same cycle stall_o=0, lu_ready=0; next posedge we_o=1, wa_o=8, wd_o=0x1234.
2. WB and JAL same cycle (wb_addr=31, data=0xA, jal_link=0x400104) -> cycle0 WB granted, stall_o=1; cycle1 JAL granted, stall_o=0; outputs in sequence wa_o=31/wd_o=0xA then wa_o=31/wd_o=0x400104; stall_cnt_o=1.
3. Starvation: wb_valid=1 every cycle, lu_valid=1 (addr=5, data=0xBEEF), STARVE_LIMIT=4 -> lu_ready=0 for 4 cycles, then one FORCE cycle with lu_ready=1, stall_o=1; next posedge wa_o=5, wd_o=0xBEEF; WB resumes the following cycle.
4. r0 write: lu_valid=1, lu_addr=0, no other requests -> lu_ready=1 immediately; next posedge we_o=0; wait_cnt stays 0.
5. Reset mid-FORCE: assert RST=0 during the FORCE cycle -> lu_ready=0, we_o=0, stall_cnt_o=0 immediately; after release with lu_valid held, LU is granted in the first cycle if WB/JAL are idle.
6. Saturation: STALL_CNT_W=4, hold jal_valid=1 and wb_valid=1 for 20 cycles -> stall_cnt_o stops at 15, no wrap.
